// File: rtl/ex_pkg.sv
// Shared encodings and widths for the execute stage: bus widths, ALU opcodes,
// result-class selects, divider iteration count and divider FSM states.
package ex_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;
    localparam int AluSelBus  = 3;
    localparam int DivCycles  = 32;

    localparam logic [AluOpBus-1:0] OP_NOP  = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] OP_AND  = 8'b0010_0100;
    localparam logic [AluOpBus-1:0] OP_OR   = 8'b0010_0101;
    localparam logic [AluOpBus-1:0] OP_XOR  = 8'b0010_0110;
    localparam logic [AluOpBus-1:0] OP_NOR  = 8'b0010_0111;
    localparam logic [AluOpBus-1:0] OP_SLL  = 8'b0111_1100;
    localparam logic [AluOpBus-1:0] OP_SRL  = 8'b0000_0010;
    localparam logic [AluOpBus-1:0] OP_SRA  = 8'b0000_0011;
    localparam logic [AluOpBus-1:0] OP_ADDU = 8'b0010_0001;
    localparam logic [AluOpBus-1:0] OP_SUBU = 8'b0010_0011;
    localparam logic [AluOpBus-1:0] OP_SLT  = 8'b0010_1010;
    localparam logic [AluOpBus-1:0] OP_SLTU = 8'b0010_1011;
    localparam logic [AluOpBus-1:0] OP_MFHI = 8'b0001_0000;
    localparam logic [AluOpBus-1:0] OP_MFLO = 8'b0001_0010;
    localparam logic [AluOpBus-1:0] OP_DIV  = 8'b0001_1010;
    localparam logic [AluOpBus-1:0] OP_DIVU = 8'b0001_1011;

    localparam logic [AluSelBus-1:0] SEL_NOP   = 3'b000;
    localparam logic [AluSelBus-1:0] SEL_LOGIC = 3'b001;
    localparam logic [AluSelBus-1:0] SEL_SHIFT = 3'b010;
    localparam logic [AluSelBus-1:0] SEL_MOVE  = 3'b011;
    localparam logic [AluSelBus-1:0] SEL_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_e;

    function automatic logic is_div(input logic [AluOpBus-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_if.sv
// ID/EX-to-EX/MEM signal bundle; master is the pipeline side, slave is ex.
interface ex_if;
    import ex_pkg::*;

    logic [AluOpBus-1:0]   aluop_i;
    logic [AluSelBus-1:0]  alusel_i;
    logic [RegBus-1:0]     reg1_i;
    logic [RegBus-1:0]     reg2_i;
    logic [RegAddrBus-1:0] wd_i;
    logic                  wreg_i;
    logic [RegBus-1:0]     hi_i;
    logic [RegBus-1:0]     lo_i;

    logic [RegAddrBus-1:0] wd_o;
    logic                  wreg_o;
    logic [RegBus-1:0]     wdata_o;
    logic                  whilo_o;
    logic [RegBus-1:0]     hi_o;
    logic [RegBus-1:0]     lo_o;
    logic                  stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider: 32 ON cycles (+1 accept cycle) per nonzero divide,
// 2 stall cycles for a zero divisor; results valid only in the END cycle.
module div
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              div_vld,
    input  logic              signed_op,
    input  logic [RegBus-1:0] op1,
    input  logic [RegBus-1:0] op2,
    output logic              stall,
    output logic              done,
    output logic [RegBus-1:0] quo,
    output logic [RegBus-1:0] rem
);

    div_state_e          state, state_nxt;
    logic [5:0]          cnt;
    logic [2*RegBus:0]   dividend;
    logic [RegBus-1:0]   divisor;
    logic                neg_quo;
    logic                neg_rem;
    logic [RegBus-1:0]   mag1, mag2;
    logic                fits;
    logic [RegBus-1:0]   sub;
    logic [RegBus-1:0]   quo_raw, rem_raw;

    assign mag1 = (signed_op && op1[RegBus-1]) ? (-op1) : op1;
    assign mag2 = (signed_op && op2[RegBus-1]) ? (-op2) : op2;

    // Partial remainder is compared as 33 bits so divisors above 2^31 still work.
    assign fits = dividend[2*RegBus:RegBus] >= {1'b0, divisor};
    assign sub  = RegBus'(dividend[2*RegBus:RegBus] - {1'b0, divisor});

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            DIV_FREE: begin
                if (div_vld) begin
                    stall     = 1'b1;
                    state_nxt = (op2 == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: begin
                stall     = 1'b1;
                state_nxt = DIV_END;
            end
            DIV_ON: begin
                stall = 1'b1;
                if (cnt == 6'(DivCycles - 1))
                    state_nxt = DIV_END;
            end
            DIV_END: begin
                done      = 1'b1;
                state_nxt = DIV_FREE;
            end
            default: state_nxt = DIV_FREE;
        endcase
        if (!rst) begin
            stall = 1'b0;
            done  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                DIV_FREE: begin
                    if (div_vld) begin
                        cnt      <= '0;
                        divisor  <= mag2;
                        neg_quo  <= signed_op && (op1[RegBus-1] ^ op2[RegBus-1]);
                        neg_rem  <= signed_op && op1[RegBus-1];
                        dividend <= {{RegBus{1'b0}}, mag1, 1'b0};
                    end
                end
                DIV_BYZERO: dividend <= '0;
                DIV_ON: begin
                    cnt <= cnt + 6'd1;
                    if (fits)
                        dividend <= {sub, dividend[RegBus-1:0], 1'b1};
                    else
                        dividend <= {dividend[2*RegBus-1:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign quo_raw = dividend[RegBus-1:0];
    assign rem_raw = dividend[2*RegBus:RegBus+1];
    assign quo     = done ? (neg_quo ? (-quo_raw) : quo_raw) : '0;
    assign rem     = done ? (neg_rem ? (-rem_raw) : rem_raw) : '0;

endmodule

// File: rtl/ex.sv
// Execute stage: combinational logic/shift/arith/move ALU plus a multi-cycle divider.
// Single-cycle for ALU ops; divides hold upstream via stallreq_o until the END cycle.
module ex
    import ex_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);

    logic [RegBus-1:0] logic_res;
    logic [RegBus-1:0] shift_res;
    logic [RegBus-1:0] arith_res;
    logic [RegBus-1:0] move_res;
    logic [4:0]        shamt;
    logic              div_vld;
    logic              div_stall;
    logic              div_done;
    logic [RegBus-1:0] div_quo;
    logic [RegBus-1:0] div_rem;

    assign shamt   = bus.reg1_i[4:0];
    assign div_vld = is_div(bus.aluop_i);

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;
        case (bus.aluop_i)
            OP_AND:  logic_res = bus.reg1_i & bus.reg2_i;
            OP_OR:   logic_res = bus.reg1_i | bus.reg2_i;
            OP_XOR:  logic_res = bus.reg1_i ^ bus.reg2_i;
            OP_NOR:  logic_res = ~(bus.reg1_i | bus.reg2_i);
            OP_SLL:  shift_res = bus.reg2_i << shamt;
            OP_SRL:  shift_res = bus.reg2_i >> shamt;
            OP_SRA:  shift_res = RegBus'($signed(bus.reg2_i) >>> shamt);
            OP_ADDU: arith_res = bus.reg1_i + bus.reg2_i;
            OP_SUBU: arith_res = bus.reg1_i - bus.reg2_i;
            OP_SLT:  arith_res = {{(RegBus-1){1'b0}}, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
            OP_SLTU: arith_res = {{(RegBus-1){1'b0}}, bus.reg1_i < bus.reg2_i};
            OP_MFHI: move_res  = bus.hi_i;
            OP_MFLO: move_res  = bus.lo_i;
            default: ;
        endcase
    end

    always_comb begin
        bus.wdata_o = '0;
        case (bus.alusel_i)
            SEL_LOGIC: bus.wdata_o = logic_res;
            SEL_SHIFT: bus.wdata_o = shift_res;
            SEL_ARITH: bus.wdata_o = arith_res;
            SEL_MOVE:  bus.wdata_o = move_res;
            default:   bus.wdata_o = '0;
        endcase
    end

    div u_div (
        .clk       (clk),
        .rst       (rst),
        .div_vld   (div_vld),
        .signed_op (bus.aluop_i == OP_DIV),
        .op1       (bus.reg1_i),
        .op2       (bus.reg2_i),
        .stall     (div_stall),
        .done      (div_done),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    assign bus.wd_o       = bus.wd_i;
    assign bus.wreg_o     = bus.wreg_i & ~div_vld;
    assign bus.whilo_o    = div_done;
    assign bus.hi_o       = div_rem;
    assign bus.lo_o       = div_quo;
    assign bus.stallreq_o = div_stall;

endmodule

// File: tb/tb_ex.sv
// Randomized bench for ex with an in-bench arithmetic model of results and divide timing.
module tb_ex;
    import ex_pkg::*;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1, r2, hi, lo;
        logic [4:0]  wd;
        logic        wreg;
        logic        lit_en;
        logic [31:0] lit_w, lit_hi, lit_lo;
    } op_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ex_if bus ();
    ex dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic [7:0] op, input logic [2:0] sel,
                               input logic [31:0] r1, input logic [31:0] r2);
        op_t o;
        o.op = op; o.sel = sel; o.r1 = r1; o.r2 = r2;
        o.hi = $urandom; o.lo = $urandom;
        o.wd = 5'($urandom); o.wreg = 1'b1;
        o.lit_en = 1'b0; o.lit_w = '0; o.lit_hi = '0; o.lit_lo = '0;
        return o;
    endfunction

    function automatic logic [31:0] ref_wdata(input op_t o);
        logic [31:0] res;
        logic [2:0]  cls;
        res = '0;
        cls = SEL_NOP;
        case (o.op)
            OP_AND:  begin cls = SEL_LOGIC; res = o.r1 & o.r2; end
            OP_OR:   begin cls = SEL_LOGIC; res = o.r1 | o.r2; end
            OP_XOR:  begin cls = SEL_LOGIC; res = o.r1 ^ o.r2; end
            OP_NOR:  begin cls = SEL_LOGIC; res = ~(o.r1 | o.r2); end
            OP_SLL:  begin cls = SEL_SHIFT; res = o.r2 << o.r1[4:0]; end
            OP_SRL:  begin cls = SEL_SHIFT; res = o.r2 >> o.r1[4:0]; end
            OP_SRA:  begin cls = SEL_SHIFT; res = 32'($signed(o.r2) >>> o.r1[4:0]); end
            OP_ADDU: begin cls = SEL_ARITH; res = o.r1 + o.r2; end
            OP_SUBU: begin cls = SEL_ARITH; res = o.r1 - o.r2; end
            OP_SLT:  begin cls = SEL_ARITH; res = ($signed(o.r1) < $signed(o.r2)) ? 32'd1 : 32'd0; end
            OP_SLTU: begin cls = SEL_ARITH; res = (o.r1 < o.r2) ? 32'd1 : 32'd0; end
            OP_MFHI: begin cls = SEL_MOVE;  res = o.hi; end
            OP_MFLO: begin cls = SEL_MOVE;  res = o.lo; end
            default: ;
        endcase
        return (cls != SEL_NOP && o.sel == cls) ? res : 32'd0;
    endfunction

    task automatic ref_div(input op_t o, output logic [31:0] q, output logic [31:0] r);
        logic        na, nb;
        logic [31:0] ma, mb;
        na = (o.op == OP_DIV) && o.r1[31];
        nb = (o.op == OP_DIV) && o.r2[31];
        ma = na ? 32'd0 - o.r1 : o.r1;
        mb = nb ? 32'd0 - o.r2 : o.r2;
        if (o.r2 == 32'd0) begin
            q = '0;
            r = '0;
        end else begin
            q = ma / mb;
            r = ma % mb;
            if (na ^ nb) q = 32'd0 - q;
            if (na)      r = 32'd0 - r;
        end
    endtask

    task automatic drive(input op_t o);
        bus.aluop_i  = o.op;
        bus.alusel_i = o.sel;
        bus.reg1_i   = o.r1;
        bus.reg2_i   = o.r2;
        bus.wd_i     = o.wd;
        bus.wreg_i   = o.wreg;
        bus.hi_i     = o.hi;
        bus.lo_i     = o.lo;
    endtask

    task automatic check_outputs(input op_t o, input int c, input int len,
                                 input logic [31:0] q, input logic [31:0] r);
        logic d;
        d = (o.op == OP_DIV) || (o.op == OP_DIVU);
        chk("wd_o", 32'(bus.wd_o), 32'(o.wd));
        chk("wreg_o", 32'(bus.wreg_o), d ? 32'd0 : 32'(o.wreg));
        chk("wdata_o", bus.wdata_o, d ? 32'd0 : ref_wdata(o));
        chk("stallreq_o", 32'(bus.stallreq_o), (d && c < len) ? 32'd1 : 32'd0);
        chk("whilo_o", 32'(bus.whilo_o), (d && c == len) ? 32'd1 : 32'd0);
        chk("hi_o", bus.hi_o, (d && c == len) ? r : 32'd0);
        chk("lo_o", bus.lo_o, (d && c == len) ? q : 32'd0);
    endtask

    // Called at a falling edge; returns one falling edge after the op retires.
    task automatic run_op(input op_t o, input int abort_at);
        logic [31:0] q, r;
        int          len;
        logic        d;
        d   = (o.op == OP_DIV) || (o.op == OP_DIVU);
        len = d ? ((o.r2 == 32'd0) ? 2 : 33) : 0;
        ref_div(o, q, r);
        for (int c = 0; c <= len; c++) begin
            if (c == 0) begin
                drive(o);
            end else begin
                @(negedge clk);
                bus.reg1_i = $urandom;
                bus.reg2_i = $urandom;
            end
            #1;
            check_outputs(o, c, len, q, r);
            if (o.lit_en && c == len) begin
                if (d) begin
                    chk("lit_lo", bus.lo_o, o.lit_lo);
                    chk("lit_hi", bus.hi_o, o.lit_hi);
                end else begin
                    chk("lit_wdata", bus.wdata_o, o.lit_w);
                end
            end
            if (c == abort_at) return;
        end
        @(negedge clk);
    endtask

    function automatic op_t rand_op();
        op_t         o;
        int          k;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a, b;
        k = $urandom_range(0, 17);
        case (k)
            0:  begin op = OP_AND;  sel = SEL_LOGIC; end
            1:  begin op = OP_OR;   sel = SEL_LOGIC; end
            2:  begin op = OP_XOR;  sel = SEL_LOGIC; end
            3:  begin op = OP_NOR;  sel = SEL_LOGIC; end
            4:  begin op = OP_SLL;  sel = SEL_SHIFT; end
            5:  begin op = OP_SRL;  sel = SEL_SHIFT; end
            6:  begin op = OP_SRA;  sel = SEL_SHIFT; end
            7:  begin op = OP_ADDU; sel = SEL_ARITH; end
            8:  begin op = OP_SUBU; sel = SEL_ARITH; end
            9:  begin op = OP_SLT;  sel = SEL_ARITH; end
            10: begin op = OP_SLTU; sel = SEL_ARITH; end
            11: begin op = OP_MFHI; sel = SEL_MOVE;  end
            12: begin op = OP_MFLO; sel = SEL_MOVE;  end
            13: begin op = OP_NOP;  sel = SEL_NOP;   end
            14: begin op = 8'hFF;   sel = 3'($urandom_range(0, 4)); end
            15, 16: begin op = OP_DIV; sel = SEL_NOP; end
            default: begin op = OP_DIVU; sel = SEL_NOP; end
        endcase
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            2: b = 32'd0 - 32'($urandom_range(1, 9));
            3: a = 32'd0 - 32'($urandom_range(0, 1000));
            default: ;
        endcase
        o = mk(op, sel, a, b);
        o.wreg = 1'($urandom);
        return o;
    endfunction

    initial begin
        op_t o;
        rst = 1'b0;
        o = mk(OP_NOP, SEL_NOP, 32'd0, 32'd0);
        drive(o);
        #2;
        chk("rst_stall", 32'(bus.stallreq_o), 32'd0);
        chk("rst_whilo", 32'(bus.whilo_o), 32'd0);
        chk("rst_hi", bus.hi_o, 32'd0);
        chk("rst_lo", bus.lo_o, 32'd0);
        o = mk(OP_DIVU, SEL_NOP, 32'd100, 32'd7);
        drive(o);
        #1;
        chk("rst_div_stall", 32'(bus.stallreq_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        o = mk(OP_OR, SEL_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F);
        o.lit_en = 1'b1; o.lit_w = 32'hF0F0_0F0F;
        run_op(o, -1);
        o = mk(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000);
        o.lit_en = 1'b1; o.lit_w = 32'hF800_0000;
        run_op(o, -1);
        o = mk(OP_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1);
        o.lit_en = 1'b1; o.lit_w = 32'd1;
        run_op(o, -1);
        o = mk(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1);
        o.lit_en = 1'b1; o.lit_w = 32'd0;
        run_op(o, -1);
        o = mk(OP_DIVU, SEL_NOP, 32'd100, 32'd7);
        o.lit_en = 1'b1; o.lit_lo = 32'd14; o.lit_hi = 32'd2;
        run_op(o, -1);
        o = mk(OP_DIV, SEL_NOP, 32'hFFFF_FFF9, 32'd2);
        o.lit_en = 1'b1; o.lit_lo = 32'hFFFF_FFFD; o.lit_hi = 32'hFFFF_FFFF;
        run_op(o, -1);
        o = mk(OP_DIVU, SEL_NOP, 32'd9, 32'd3);
        o.lit_en = 1'b1; o.lit_lo = 32'd3; o.lit_hi = 32'd0;
        run_op(o, -1);
        o = mk(OP_DIVU, SEL_NOP, 32'd5, 32'd0);
        o.lit_en = 1'b1; o.lit_lo = 32'd0; o.lit_hi = 32'd0;
        run_op(o, -1);
        o = mk(OP_DIV, SEL_NOP, 32'h8000_0000, 32'hFFFF_FFFF);
        o.lit_en = 1'b1; o.lit_lo = 32'h8000_0000; o.lit_hi = 32'd0;
        run_op(o, -1);
        o = mk(OP_DIVU, SEL_NOP, 32'hFFFF_FFFF, 32'h8000_0001);
        o.lit_en = 1'b1; o.lit_lo = 32'd1; o.lit_hi = 32'h7FFF_FFFE;
        run_op(o, -1);

        // Abort a divide in its tenth ON cycle, then divide again from clean state.
        o = mk(OP_DIVU, SEL_NOP, 32'd1000, 32'd3);
        run_op(o, 10);
        rst = 1'b0;
        #1;
        chk("abort_stall", 32'(bus.stallreq_o), 32'd0);
        chk("abort_whilo", 32'(bus.whilo_o), 32'd0);
        o = mk(OP_DIVU, SEL_NOP, 32'd8, 32'd2);
        o.lit_en = 1'b1; o.lit_lo = 32'd4; o.lit_hi = 32'd0;
        drive(o);
        #1;
        chk("abort_hold_stall", 32'(bus.stallreq_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(o, -1);

        for (int i = 0; i < 300; i++) begin
            o = rand_op();
            run_op(o, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex.md
EX -- requirements
Module: ex

Interface
REQ-001 SHALL have defaults from the shared defines: RegBus=32 (data width), RegAddrBus=5 (register address), AluOpBus=8 (ALU opcode), AluSelBus=3 (result select), DivCycles=32 (divider iterations).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset; asynchronous and active-low (rst=0 resets).
REQ-004 aluop_i  in  AluOpBus  opcode from the ID/EX register.
REQ-005 alusel_i  in  AluSelBus  result class: NOP, LOGIC, SHIFT, ARITH, MOVE.
REQ-006 reg1_i, reg2_i  in  RegBus  operands; for shifts, reg1_i[4:0] is the shift amount.
REQ-007 wd_i  in  RegAddrBus  destination register.
REQ-008 wreg_i  in  1  GPR write enable.
REQ-009 hi_i, lo_i  in  RegBus  current HI/LO values, already forwarded.
REQ-010 wd_o  out  RegAddrBus  destination register to EX/MEM.
REQ-011 wreg_o  out  1  GPR write enable to EX/MEM.
REQ-012 wdata_o  out  RegBus  GPR write data to EX/MEM.
REQ-013 whilo_o  out  1  HI/LO write enable to EX/MEM.
REQ-014 hi_o, lo_o  out  RegBus  HI/LO write data (HI=remainder, LO=quotient).
REQ-015 stallreq_o  out  1  holds the upstream stages and the ID/EX register while the divider is busy.

Function
REQ-016 LOGIC class SHALL compute AND, OR, XOR and NOR combinationally.
REQ-017 SHIFT class SHALL compute SLL, SRL and SRA (arithmetic fill) of reg2_i by reg1_i[4:0] combinationally.
REQ-018 ARITH class SHALL compute ADDU and SUBU modulo 2^32, plus SLT (signed) and SLTU (unsigned) giving 32'h1 or 32'h0; no overflow trap.
REQ-019 MOVE class SHALL give MFHI->hi_i and MFLO->lo_i on wdata_o.
REQ-020 NOP class or unknown opcode SHALL drive wdata_o=0, and the HI/LO write SHALL be disabled.
REQ-021 wd_o SHALL equal wd_i; wreg_o SHALL equal wreg_i for non-divide ops and SHALL be 0 for DIV/DIVU.
REQ-022 The divider FSM SHALL have the states FREE, BYZERO, ON and END; the state register is the only sequential state besides the divider datapath.
REQ-023 FREE: when DIV/DIVU is present and reg2_i!=0, the FSM SHALL go to ON and latch the operand magnitudes (signed ops negate negative operands).
REQ-024 FREE: when DIV/DIVU is present and reg2_i==0, the FSM SHALL go to BYZERO.
REQ-025 ON SHALL run one restoring shift-subtract step per cycle on a 65-bit dividend register with a 6-bit counter, then go to END after DivCycles steps.
REQ-026 BYZERO SHALL go to END after 1 cycle with quotient=0 and remainder=0.
REQ-027 END SHALL fix the result signs for DIV: the quotient is negative when the operand signs differ, and the remainder takes the dividend's sign.
REQ-028 END SHALL drive hi_o/lo_o from the divider, assert whilo_o=1 and hold stallreq_o=0, then go to FREE unconditionally.
REQ-029 stallreq_o SHALL be 1 combinationally in FREE while a divide op is present, and 1 throughout BYZERO and ON.
REQ-030 Latency: a nonzero-divisor divide SHALL stall 33 cycles (ops-present cycle plus 32 ON cycles), with results in the END cycle; a zero-divisor divide SHALL stall 2 cycles.
REQ-031 Back-to-back divides: the second divide SHALL start from FREE in the cycle after END; the END cycle SHALL never restart the divider.
REQ-032 Operands SHALL be sampled only in FREE; upstream holds them stable, but any change during ON SHALL not affect the result.
REQ-033 For non-divide ops, whilo_o=0 and hi_o=lo_o=0.

Reset
REQ-034 rst=0 SHALL force the FSM to FREE, the counter to 0 and the dividend register to 0 immediately, without waiting for clk.
REQ-035 Reset mid-division SHALL abort the divide; stallreq_o=0 and whilo_o=0 SHALL follow while rst=0.
REQ-036 Reset release SHALL be synchronous to the first clk edge with rst=1.

Structure
REQ-037 Opcode and select encodings, the bus widths, DivCycles and the FSM state encodings SHALL live in the shared defines package.
REQ-038 The divider FSM and datapath SHALL be one sub-module, div; ex SHALL hold the combinational ALU and the result mux.

Verification
REQ-039 OR: reg1=32'hF0F0_0000, reg2=32'h0000_0F0F -> wdata_o=32'hF0F0_0F0F, wreg_o=1, stallreq_o=0.
REQ-040 SRA: reg1=4, reg2=32'h8000_0000 -> wdata_o=32'hF800_0000; SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
REQ-041 DIVU: 100/7 -> stallreq_o high 33 cycles, then END with lo_o=14, hi_o=2, whilo_o=1.
REQ-042 DIV: -7/2 -> lo_o=32'hFFFF_FFFD, hi_o=32'hFFFF_FFFF; then an immediate DIVU 9/3 -> lo_o=3, hi_o=0 after a fresh 33-cycle stall.
REQ-043 Divide by zero: 5/0 -> stallreq_o high 2 cycles, then hi_o=lo_o=0 with whilo_o=1.
REQ-044 Reset mid-division: rst=0 at ON cycle 10 -> stallreq_o=0 at once and FSM in FREE; after release, DIVU 8/2 -> lo_o=4.
